// File: rtl/pc_run_ctrl.sv
// Run/step sequencer deciding when the IF-stage PC and the pipeline registers advance.
// Optional cycle counter output enabled by defining PC_RUN_CTRL_CYCLE_CNT_EN.
module pc_run_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned NB_CNT       = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_mode_step,
    input  logic              i_step,
    input  logic              i_stall,
    input  logic              i_halt,
    output logic              o_pc_enable,
    output logic              o_pipe_enable,
    output logic              o_done,
`ifdef PC_RUN_CTRL_CYCLE_CNT_EN
    output logic [2:0]        o_state,
    output logic [NB_CNT-1:0] o_cycle_cnt
`else
    output logic [2:0]        o_state
`endif
);

    localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRun      = 3'd1,
        StStepWait = 3'd2,
        StStepExec = 3'd3,
        StDrain    = 3'd4,
        StDone     = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] drain_q, drain_d;
    logic            step_q;
    logic            step_rise;
    logic            pc_en;
    logic            pipe_en;

    assign step_rise = i_step & ~step_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            drain_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            step_q  <= i_step;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        pc_en   = 1'b0;
        pipe_en = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = i_mode_step ? StStepWait : StRun;
                end
            end
            StRun: begin
                pipe_en = 1'b1;
                pc_en   = ~i_halt & ~i_stall;
                if (i_halt) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                end
            end
            StStepWait: begin
                if (step_rise) begin
                    state_d = StStepExec;
                end
            end
            StStepExec: begin
                // A stalled step still clocks the pipeline, inserting a bubble.
                pipe_en = 1'b1;
                pc_en   = ~i_halt & ~i_stall;
                if (i_halt) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                end else begin
                    state_d = StStepWait;
                end
            end
            StDrain: begin
                pipe_en = 1'b1;
                if (drain_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset must force the enables low even though they are decoded combinationally.
    assign o_pc_enable   = pc_en & ~i_reset;
    assign o_pipe_enable = pipe_en & ~i_reset;
    assign o_done        = (state_q == StDone);
    assign o_state       = state_q;

`ifdef PC_RUN_CTRL_CYCLE_CNT_EN
    logic [NB_CNT-1:0] cycle_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cycle_cnt_q <= '0;
        end else if ((state_q == StIdle) && (state_d != StIdle)) begin
            cycle_cnt_q <= '0;
        end else if (pipe_en) begin
            cycle_cnt_q <= cycle_cnt_q + 1'b1;
        end
    end

    assign o_cycle_cnt = cycle_cnt_q;
`else
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = ^NB_CNT;
`endif

endmodule
